serial_subtractor: RTL and testbench

Parametrised multi-cycle subtractor computing diff = a - b - bin over WIDTH bits, DIGIT bits per clock, starting at the LSB digit. It carries the borrow between digits in a register, so one narrow full-subtractor slice replaces a WIDTH-wide ripple chain. It is the sequential successor to the single-bit half/full subtractor cells and serves area-constrained datapaths that can accept multi-cycle latency. Start/busy/done handshake; registered result with borrow-out and signed-overflow flags.

---
 rtl/serial_subtractor_if.sv | 18 +
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake bundle for the digit-serial subtractor.
// The requester drives operands and start; the subtractor returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial a - b - bin: one DIGIT-wide subtract slice per clock, LSB digit first,
// borrow carried between digits in a register; result, borrow-out and overflow registered.
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_subtractor_if.slave    bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d, bout_q, bout_d, ovf_q, ovf_d, done_q, done_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] res_nxt;

  // Top bit of the (DIGIT+1)-bit difference is the borrow out of this digit.
  assign slice = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, br_q};

  generate
    if (DIGIT == WIDTH) begin : g_one_digit
      assign res_nxt = slice[DIGIT-1:0];
    end else begin : g_multi_digit
      assign res_nxt = {slice[DIGIT-1:0], res_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          amsb_d  = bus.a[WIDTH-1];
          bmsb_d  = bus.b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = res_nxt;
        br_d  = slice[DIGIT];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          diff_d  = res_nxt;
          bout_d  = slice[DIGIT];
          // Operand msbs were captured at start since the shift registers lose them.
          ovf_d   = (amsb_q != bmsb_q) && (res_nxt[WIDTH-1] != amsb_q);
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: two subtractor configurations (8b x 1-bit digits, 16b x 4-bit digits)
// checked against an arithmetic reference model of a - b - bin.
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(8))  i8 ();
  serial_subtractor_if #(.WIDTH(16)) i16 ();

  serial_subtractor #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(i8));
  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(i16));

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  int   dt8[$];
  exp_t e8, e16;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Plain integer arithmetic: unsigned difference for diff/bout, signed range test for ovf.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic bin);
    exp_t e;
    int ua, ub, full, sa, sb, s;
    ua   = int'(a);
    ub   = int'(b);
    full = ua - ub - int'(bin);
    e.diff = 16'(full & ((1 << w) - 1));
    e.bout = (full < 0);
    sa = a[w-1] ? ua - (1 << w) : ua;
    sb = b[w-1] ? ub - (1 << w) : ub;
    s  = sa - sb - int'(bin);
    e.ovf = (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (i8.done) begin
        dt8.push_back(cyc);
        chk("dut8 done while busy", longint'(i8.busy), 0);
        if (q8.size() == 0) chk("dut8 unexpected done", 1, 0);
        else begin
          e8 = q8.pop_front();
          chk("dut8 diff", longint'(i8.diff), longint'(e8.diff[7:0]));
          chk("dut8 bout", longint'(i8.bout), longint'(e8.bout));
          chk("dut8 ovf",  longint'(i8.ovf),  longint'(e8.ovf));
        end
      end
      if (i16.done) begin
        chk("dut16 done while busy", longint'(i16.busy), 0);
        if (q16.size() == 0) chk("dut16 unexpected done", 1, 0);
        else begin
          e16 = q16.pop_front();
          chk("dut16 diff", longint'(i16.diff), longint'(e16.diff));
          chk("dut16 bout", longint'(i16.bout), longint'(e16.bout));
          chk("dut16 ovf",  longint'(i16.ovf),  longint'(e16.ovf));
        end
      end
    end
  end

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit timing);
    int g, lat, bc;
    g = 0;
    while (i8.busy && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("dut8 idle timeout", 1, 0);
    i8.start = 1'b1; i8.a = a; i8.b = b; i8.bin = bin;
    q8.push_back(model(8, {8'h00, a}, {8'h00, b}, bin));
    @(negedge clk);
    i8.start = 1'b0;
    if (timing) begin
      bc = int'(i8.busy);
      lat = 0;
      while (lat < 200) begin
        @(negedge clk);
        lat++;
        if (i8.done) break;
        bc += int'(i8.busy);
      end
      chk("dut8 latency", lat, 8);
      chk("dut8 busy cycles", bc, 8);
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic bin, input bit timing);
    int g, lat;
    g = 0;
    while (i16.busy && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("dut16 idle timeout", 1, 0);
    i16.start = 1'b1; i16.a = a; i16.b = b; i16.bin = bin;
    q16.push_back(model(16, a, b, bin));
    @(negedge clk);
    i16.start = 1'b0;
    if (timing) begin
      lat = 0;
      while (lat < 200) begin
        @(negedge clk);
        lat++;
        if (i16.done) break;
      end
      chk("dut16 latency", lat, 4);
    end
  endtask

  task automatic wait_idle8();
    int g;
    g = 0;
    while (i8.busy && g < 200) begin @(negedge clk); g++; end
    if (g >= 200) chk("dut8 idle timeout", 1, 0);
  endtask

  initial begin
    int nd;
    i8.start = 1'b0;  i8.a = '0;  i8.b = '0;  i8.bin = 1'b0;
    i16.start = 1'b0; i16.a = '0; i16.b = '0; i16.bin = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy",  longint'(i8.busy), 0);
    chk("reset done",  longint'(i8.done), 0);
    chk("reset diff",  longint'(i8.diff), 0);
    chk("reset bout",  longint'(i8.bout), 0);
    chk("reset ovf",   longint'(i8.ovf), 0);
    chk("reset busy16", longint'(i16.busy), 0);
    chk("reset diff16", longint'(i16.diff), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run8(8'h35, 8'h12, 1'b0, 1'b1);
    run8(8'h00, 8'h01, 1'b0, 1'b1);
    run8(8'h10, 8'h10, 1'b1, 1'b1);
    run8(8'h80, 8'h01, 1'b0, 1'b1);
    run8(8'h7F, 8'hFF, 1'b0, 1'b1);
    run16(16'h1234, 16'h0FFF, 1'b1, 1'b1);
    run16(16'h8000, 16'h0001, 1'b0, 1'b1);

    // Mid-run start with other operands must be ignored.
    run8(8'hC3, 8'h5A, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    i8.start = 1'b1; i8.a = 8'h11; i8.b = 8'h99; i8.bin = 1'b0;
    @(negedge clk);
    i8.start = 1'b0;
    wait_idle8();
    repeat (3) @(negedge clk);

    // Held start: accepted every N+1 = 9 cycles, operands changing each cycle.
    dt8.delete();
    for (int k = 0; k < 19; k++) begin
      i8.start = 1'b1;
      i8.a = 8'($urandom); i8.b = 8'($urandom); i8.bin = 1'($urandom_range(0, 1));
      if (k % 9 == 0) q8.push_back(model(8, {8'h00, i8.a}, {8'h00, i8.b}, i8.bin));
      @(negedge clk);
    end
    i8.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("held start done count", dt8.size(), 3);
    if (dt8.size() == 3) begin
      chk("held start interval 1", dt8[1] - dt8[0], 9);
      chk("held start interval 2", dt8[2] - dt8[1], 9);
    end

    // Reset at cycle 3 of an operation discards it.
    run8(8'h5A, 8'h21, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst busy", longint'(i8.busy), 0);
    chk("midrst done", longint'(i8.done), 0);
    chk("midrst diff", longint'(i8.diff), 0);
    chk("midrst bout", longint'(i8.bout), 0);
    chk("midrst ovf",  longint'(i8.ovf), 0);
    q8.delete();
    q16.delete();
    rst_n = 1'b1;
    nd = 0;
    repeat (15) begin @(negedge clk); nd += int'(i8.done); end
    chk("no done after reset", nd, 0);

    for (int i = 0; i < 40; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    for (int i = 0; i < 30; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), (i % 10) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk("dut8 queue drained", q8.size(), 0);
    chk("dut16 queue drained", q16.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
